// File: rtl/m72_pkg.sv
// Shared constants and types for the M72 video I/O blocks.
package m72_pkg;

   localparam int OBJ_WORDS = 512;
   localparam int OBJ_AW    = 9;
   localparam int OBJ_DW    = 16;

   typedef enum logic [1:0] {
      DMA_IDLE,
      DMA_COPY,
      DMA_FINISH
   } dma_state_t;

endpackage

// File: rtl/obj_dma_if.sv
// Object RAM read port, sprite-list buffer write port and DMA status.
interface obj_dma_if
   import m72_pkg::*;
#(
   parameter int AW = OBJ_AW,
   parameter int DW = OBJ_DW
);

   logic [AW-1:0] obj_addr;
   logic [DW-1:0] obj_data;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_data;
   logic          buf_we;
   logic          busy;
   logic          done;

   modport master (
      output obj_addr,
      input  obj_data,
      output buf_addr,
      output buf_data,
      output buf_we,
      output busy,
      output done
   );

   modport slave (
      input  obj_addr,
      output obj_data,
      input  buf_addr,
      input  buf_data,
      input  buf_we,
      input  busy,
      input  done
   );

endinterface

// File: rtl/obj_dma_ce_edge_detect.sv
// Rising-edge detector whose history register only advances on ce cycles,
// so an edge seen while ce is low is reported on the next ce cycle.
module ce_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  logic d,
   output logic rise
);

   logic d_q;

   // previous-sample register, held while ce is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         d_q <= 1'b0;
      else if (ce)
         d_q <= d;
   end

   assign rise = ce & d & ~d_q;

endmodule

// File: rtl/obj_dma.sv
// Sprite-list DMA: an arm from the DMA_ON port is latched as pending, and the
// next vblank rising edge copies object RAM into the sprite-list buffer.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   DMA_IDLE   | waiting for pending & vblank rise
//   DMA_COPY   | one read per ce cycle; writes trail reads by one ce cycle
//   DMA_FINISH | single ce cycle after the last write, done pulses
module obj_dma
   import m72_pkg::*;
#(
   parameter int WORDS = OBJ_WORDS,
   parameter int AW    = OBJ_AW,
   parameter int DW    = OBJ_DW
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ce,
   input  logic         dma_on,
   input  logic         vblank,
   obj_dma_if.master    bus
);

   localparam logic [AW:0]   RD_END  = (AW+1)'(WORDS);
   localparam logic [AW-1:0] WR_LAST = AW'(WORDS-1);

   dma_state_t    state, state_nx;
   logic          arm, vb_rise;
   logic          pending;
   logic          primed;
   logic [AW:0]   rd_cnt;
   logic [AW-1:0] obj_addr_q;
   logic [AW-1:0] wr_cnt;
   logic          start, wr_en, last_wr, we;
   logic [DW-1:0] wr_data;

   ce_edge_detect u_arm_edge (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .d     (dma_on),
      .rise  (arm)
   );

   ce_edge_detect u_vb_edge (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .d     (vblank),
      .rise  (vb_rise)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= DMA_IDLE;
      else if (ce)
         state <= state_nx;
   end

   // next state and per-cycle control strobes
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      wr_en    = 1'b0;
      last_wr  = 1'b0;
      case (state)
         DMA_IDLE: begin
            if (pending && vb_rise) begin
               start    = 1'b1;
               state_nx = DMA_COPY;
            end
         end
         DMA_COPY: begin
            wr_en = primed;
            if (primed && wr_cnt == WR_LAST) begin
               last_wr  = 1'b1;
               state_nx = DMA_FINISH;
            end
         end
         DMA_FINISH: begin
            state_nx = DMA_IDLE;
         end
         default: begin
            state_nx = DMA_IDLE;
         end
      endcase
   end

   // pending flag, read/write counters and read address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending    <= 1'b0;
         primed     <= 1'b0;
         rd_cnt     <= '0;
         obj_addr_q <= '0;
         wr_cnt     <= '0;
      end else if (ce) begin
         // an arm landing on the start cycle belongs to the next frame
         if (arm)
            pending <= 1'b1;
         else if (start)
            pending <= 1'b0;

         if (start) begin
            // address 0 goes out now; rd_cnt holds the next address to issue
            primed     <= 1'b0;
            rd_cnt     <= {{AW{1'b0}}, 1'b1};
            obj_addr_q <= '0;
            wr_cnt     <= '0;
         end else if (state == DMA_COPY) begin
            primed <= 1'b1;
            if (rd_cnt != RD_END) begin
               obj_addr_q <= rd_cnt[AW-1:0];
               rd_cnt     <= rd_cnt + 1'b1;
            end
            if (wr_en && !last_wr)
               wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   assign we      = wr_en & ce;
   assign wr_data = we ? bus.obj_data : '0;

   assign bus.obj_addr = obj_addr_q;
   assign bus.buf_addr = wr_cnt;
   assign bus.buf_data = wr_data;
   assign bus.buf_we   = we;
   assign bus.busy     = (state == DMA_COPY);
   assign bus.done     = (state == DMA_FINISH) & ce;

endmodule

// File: tb/tb_obj_dma.sv
// Directed bench for obj_dma: cycle vector table around arming and the first
// words of a copy, then multi-cycle sequences for the frame-level cases.
module tb_obj_dma;

   logic clk = 1'b0;
   logic reset;
   logic ce;
   logic dma_on;
   logic vblank;

   obj_dma_if bus ();

   obj_dma dut (
      .clk    (clk),
      .reset  (reset),
      .ce     (ce),
      .dma_on (dma_on),
      .vblank (vblank),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [512];
   logic [15:0] key;

   // synchronous object RAM, one ce cycle of read latency
   always @(posedge clk) begin
      if (ce)
         bus.obj_data <= mem[bus.obj_addr];
   end

   int checks = 0;
   int errors = 0;

   int mon_wr = 0;
   int mon_busy = 0;
   int mon_done = 0;
   int mon_addr_err = 0;
   int mon_data_err = 0;
   logic [8:0] exp_addr = '0;
   logic busy_prev = 1'b0;

   // write monitor: ascending addresses from 0, data = addr ^ key
   always @(negedge clk) begin
      if (bus.busy && !busy_prev)
         exp_addr = '0;
      busy_prev = bus.busy;
      if (bus.busy)
         mon_busy++;
      if (bus.done)
         mon_done++;
      if (bus.buf_we) begin
         if (bus.buf_addr !== exp_addr)
            mon_addr_err++;
         if (bus.buf_data !== ({7'd0, bus.buf_addr} ^ key))
            mon_data_err++;
         exp_addr = exp_addr + 9'd1;
         mon_wr++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic load_mem(input logic [15:0] k);
      key = k;
      for (int i = 0; i < 512; i++)
         mem[i] = i[15:0] ^ k;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_until_done(input int ce_div, input int ce_phase, input int budget, output bit ok);
      int d0;
      d0 = mon_done;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         ce = ((i % ce_div) == ce_phase);
         @(negedge clk);
         #1;
         if (mon_done != d0)
            ok = 1'b1;
         @(posedge clk);
         #1;
      end
      ce = 1'b1;
   endtask

   task automatic run_until_writes(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         ce = 1'b1;
         @(negedge clk);
         #1;
         if (mon_wr >= target)
            ok = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   typedef struct {
      logic        ce;
      logic        dma_on;
      logic        vblank;
      logic        exp_busy;
      logic        exp_we;
      logic        exp_done;
      logic [8:0]  exp_oa;
      logic [8:0]  exp_ba;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs [13];

   initial begin
      bit ok;
      int w0, b0, d0;

      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'd1, 9'd0, 16'hA5A5};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'd2, 9'd1, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd2, 9'd1, 16'hA5A4};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 9'd3, 9'd2, 16'hA5A7};

      reset  = 1'b1;
      ce     = 1'b0;
      dma_on = 1'b0;
      vblank = 1'b0;
      load_mem(16'hA5A5);
      cyc(3);

      check("rst_obj_addr", bus.obj_addr, 0);
      check("rst_buf_addr", bus.buf_addr, 0);
      check("rst_buf_data", bus.buf_data, 0);
      check("rst_buf_we",   bus.buf_we,   0);
      check("rst_busy",     bus.busy,     0);
      check("rst_done",     bus.done,     0);

      reset = 1'b0;
      ce    = 1'b1;

      // T1: vector table, then let the copy run out
      w0 = mon_wr; b0 = mon_busy; d0 = mon_done;
      for (int i = 0; i < 13; i++) begin
         ce     = vecs[i].ce;
         dma_on = vecs[i].dma_on;
         vblank = vecs[i].vblank;
         @(negedge clk);
         check($sformatf("vec%0d_busy", i),     bus.busy,     vecs[i].exp_busy);
         check($sformatf("vec%0d_we", i),       bus.buf_we,   vecs[i].exp_we);
         check($sformatf("vec%0d_done", i),     bus.done,     vecs[i].exp_done);
         check($sformatf("vec%0d_obj_addr", i), bus.obj_addr, vecs[i].exp_oa);
         check($sformatf("vec%0d_buf_addr", i), bus.buf_addr, vecs[i].exp_ba);
         check($sformatf("vec%0d_buf_data", i), bus.buf_data, vecs[i].exp_data);
         @(posedge clk);
         #1;
      end
      run_until_done(1, 0, 700, ok);
      check("t1_done_seen",  ok, 1);
      check("t1_writes",     mon_wr - w0, 512);
      check("t1_busy_clks",  mon_busy - b0, 514);
      check("t1_done_count", mon_done - d0, 1);
      check("t1_addr_err",   mon_addr_err, 0);
      check("t1_data_err",   mon_data_err, 0);
      check("t1_final_baddr", bus.buf_addr, 511);
      check("t1_final_oaddr", bus.obj_addr, 511);

      // T2: vblank without an arm does nothing
      w0 = mon_wr; b0 = mon_busy; d0 = mon_done;
      vblank = 1'b1;
      cyc(600);
      vblank = 1'b0;
      cyc(5);
      check("t2_writes", mon_wr - w0, 0);
      check("t2_busy",   mon_busy - b0, 0);
      check("t2_done",   mon_done - d0, 0);

      // T3: 3-cycle dma_on, vblank rise 100 cycles later
      load_mem(16'hA5A5);
      w0 = mon_wr; b0 = mon_busy; d0 = mon_done;
      dma_on = 1'b1;
      cyc(3);
      dma_on = 1'b0;
      cyc(100);
      vblank = 1'b1;
      run_until_done(1, 0, 700, ok);
      check("t3_done_seen",  ok, 1);
      check("t3_writes",     mon_wr - w0, 512);
      check("t3_busy_clks",  mon_busy - b0, 513);
      check("t3_done_count", mon_done - d0, 1);
      check("t3_addr_err",   mon_addr_err, 0);
      check("t3_data_err",   mon_data_err, 0);

      // T4: re-arm at word 200, second copy on the next vblank
      vblank = 1'b0;
      load_mem(16'h1234);
      cyc(3);
      w0 = mon_wr; d0 = mon_done;
      dma_on = 1'b1;
      cyc(1);
      dma_on = 1'b0;
      cyc(2);
      vblank = 1'b1;
      run_until_writes(w0 + 200, 700, ok);
      check("t4_reach_200", ok, 1);
      dma_on = 1'b1;
      run_until_done(1, 0, 700, ok);
      dma_on = 1'b0;
      check("t4_done1_seen", ok, 1);
      check("t4_writes1",    mon_wr - w0, 512);
      check("t4_done1",      mon_done - d0, 1);
      vblank = 1'b0;
      cyc(3);
      w0 = mon_wr;
      vblank = 1'b1;
      run_until_done(1, 0, 700, ok);
      check("t4_done2_seen", ok, 1);
      check("t4_writes2",    mon_wr - w0, 512);
      check("t4_addr_err",   mon_addr_err, 0);
      check("t4_data_err",   mon_data_err, 0);

      // T5: ce high one clock in four during the copy
      vblank = 1'b0;
      load_mem(16'h0F0F);
      cyc(3);
      w0 = mon_wr; b0 = mon_busy; d0 = mon_done;
      dma_on = 1'b1;
      cyc(1);
      dma_on = 1'b0;
      cyc(2);
      vblank = 1'b1;
      run_until_done(4, 3, 2200, ok);
      check("t5_done_seen",  ok, 1);
      check("t5_writes",     mon_wr - w0, 512);
      check("t5_busy_clks",  mon_busy - b0, 2052);
      check("t5_done_count", mon_done - d0, 1);
      check("t5_addr_err",   mon_addr_err, 0);
      check("t5_data_err",   mon_data_err, 0);

      // T6: asynchronous reset at word 300
      vblank = 1'b0;
      cyc(3);
      w0 = mon_wr; d0 = mon_done;
      dma_on = 1'b1;
      cyc(1);
      dma_on = 1'b0;
      cyc(2);
      vblank = 1'b1;
      run_until_writes(w0 + 300, 700, ok);
      check("t6_reach_300", ok, 1);
      reset = 1'b1;
      #1;
      check("t6_rst_we",       bus.buf_we,   0);
      check("t6_rst_busy",     bus.busy,     0);
      check("t6_rst_obj_addr", bus.obj_addr, 0);
      check("t6_rst_buf_addr", bus.buf_addr, 0);
      cyc(2);
      reset = 1'b0;
      cyc(5);
      check("t6_writes", mon_wr - w0, 300);
      check("t6_done",   mon_done - d0, 0);
      vblank = 1'b0;
      cyc(3);
      vblank = 1'b1;
      cyc(600);
      check("t6_no_copy", mon_wr - w0, 300);

      // T7: arm coincides with vblank rise while already pending
      vblank = 1'b0;
      load_mem(16'h6C3E);
      cyc(3);
      w0 = mon_wr;
      dma_on = 1'b1;
      cyc(1);
      dma_on = 1'b0;
      cyc(2);
      dma_on = 1'b1;
      vblank = 1'b1;
      run_until_done(1, 0, 700, ok);
      check("t7_done1_seen", ok, 1);
      check("t7_writes1",    mon_wr - w0, 512);
      dma_on = 1'b0;
      vblank = 1'b0;
      cyc(3);
      w0 = mon_wr;
      vblank = 1'b1;
      run_until_done(1, 0, 700, ok);
      check("t7_done2_seen", ok, 1);
      check("t7_writes2",    mon_wr - w0, 512);
      vblank = 1'b0;
      cyc(3);
      w0 = mon_wr;
      vblank = 1'b1;
      cyc(600);
      check("t7_third_idle", mon_wr - w0, 0);
      check("t7_addr_err",   mon_addr_err, 0);
      check("t7_data_err",   mon_data_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
